apb_slave_regs: RTL and testbench

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

---
 rtl/apb_pkg.sv | 24 ++
 rtl/apb_regfile.sv | 58 +++++
 rtl/apb_slave_regs.sv | 129 ++++++++++++
 tb/tb_apb_slave_regs.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB register slave: FSM state encoding, register
// index constants, the default identification word and the address-error rule.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } apb_state_e;

  localparam int unsigned NumDataRegs = 6;
  localparam logic [2:0]  REG_CNT     = 3'd6;
  localparam logic [2:0]  REG_ID      = 3'd7;
  localparam logic [31:0] ID_DEFAULT  = 32'hA9B0_0001;

  // An access errors when it falls outside the 32-byte window, is not word
  // aligned, or tries to write one of the read-only words.
  function automatic logic addr_err(input logic [31:0] addr, input logic write);
    logic ro_hit;
    ro_hit = (addr[4:2] == REG_CNT) || (addr[4:2] == REG_ID);
    return (addr[31:5] != '0) || (addr[1:0] != 2'b00) || (write && ro_hit);
  endfunction

endpackage

// File: rtl/apb_regfile.sv
// Register file for the APB slave: six RW data words, a read-only write counter
// and a read-only identification word.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   we          commit a write this cycle (also bumps the write counter)
//   widx, wdata word index and data of the write
//   ridx        word index to read
//   rdata       combinational read data for ridx
module apb_regfile
  import apb_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we,
  input  logic [2:0]  widx,
  input  logic [31:0] wdata,
  input  logic [2:0]  ridx,
  output logic [31:0] rdata
);

  logic [31:0] data_q [NumDataRegs];
  logic [31:0] wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumDataRegs; i++) begin
        data_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else if (we) begin
      for (int i = 0; i < NumDataRegs; i++) begin
        if (widx == 3'(i)) begin
          data_q[i] <= wdata;
        end
      end
      // Wraps naturally from all-ones to zero.
      wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NumDataRegs; i++) begin
      if (ridx == 3'(i)) begin
        rdata = data_q[i];
      end
    end
    if (ridx == REG_CNT) begin
      rdata = wr_cnt_q;
    end
    if (ridx == REG_ID) begin
      rdata = ID_VALUE;
    end
  end

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave with a small register map and a programmable number of wait states.
// Parameters:
//   WAIT_CYCLES  access-phase cycles with pready low before pready high (0..15)
//   ID_VALUE     read-only identification word at index 7
// Ports:
//   clk, rst_n             clock and asynchronous active-low reset
//   psel, penable, pwrite  APB control from the requester
//   paddr, pwdata          byte address and write data
//   prdata                 registered read data, valid while pready on a read
//   pready                 transfer complete
//   pslverr                error response, valid only while pready
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = ID_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  localparam logic [3:0] WaitLoad = 4'(WAIT_CYCLES);

  apb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, wdata_q, prdata_q, prdata_d;
  logic        write_q;
  logic        capture, load_rdata, commit;

  logic [31:0] rd_addr, rf_rdata;
  logic        rd_write, rd_err, cur_err;

  // With zero wait states READY is entered on the setup edge itself, before the
  // address is captured, so the read path looks at the live bus in IDLE.
  assign rd_addr  = (state_q == StIdle) ? paddr : addr_q;
  assign rd_write = (state_q == StIdle) ? pwrite : write_q;
  assign rd_err   = addr_err(rd_addr, rd_write);
  assign cur_err  = addr_err(addr_q, write_q);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    load_rdata = 1'b0;
    commit     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (psel && !penable) begin
          capture = 1'b1;
          cnt_d   = WaitLoad;
          if (WaitLoad == 4'd0) begin
            state_d    = StReady;
            load_rdata = !pwrite;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (!psel) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = StReady;
            load_rdata = !write_q;
          end
        end
      end
      StReady: begin
        state_d = StIdle;
        commit  = psel && penable && write_q && !cur_err;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    prdata_d = prdata_q;
    if (load_rdata) begin
      prdata_d = rd_err ? 32'h0 : rf_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prdata_q <= prdata_d;
      if (capture) begin
        addr_q  <= paddr;
        wdata_q <= pwdata;
        write_q <= pwrite;
      end
    end
  end

  apb_regfile #(
    .ID_VALUE(ID_VALUE)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (commit),
    .widx (addr_q[4:2]),
    .wdata(wdata_q),
    .ridx (rd_addr[4:2]),
    .rdata(rf_rdata)
  );

  assign prdata  = prdata_q;
  assign pready  = (state_q == StReady);
  assign pslverr = (state_q == StReady) && cur_err;

endmodule

// File: tb/tb_apb_slave_regs.sv
module tb_apb_slave_regs;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [2:0]  psel_v, pready_v, pslverr_v;
  logic [31:0] prdata_v [3];

  always #5 clk = ~clk;

  // Three instances sharing the bus, one per wait-state setting (0, 1, 3).
  apb_slave_regs #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[0]), .pready(pready_v[0]),
    .pslverr(pslverr_v[0])
  );
  apb_slave_regs #(.WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[1]), .pready(pready_v[1]),
    .pslverr(pslverr_v[1])
  );
  apb_slave_regs #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst_n(rst_n), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata_v[2]), .pready(pready_v[2]),
    .pslverr(pslverr_v[2])
  );

  // Behavioural model: word array per instance (6 = counter, 7 = ID).
  logic [31:0] m_reg [3][8];
  logic [31:0] m_prdata [3];
  logic [2:0]  exp_ready, exp_err;
  bit          chk_en;
  int          n_pass, n_total;

  function automatic int wait_of(input int i);
    case (i)
      0:       return 0;
      1:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic bit model_err(input logic [31:0] addr, input bit wr);
    int idx;
    idx = int'(addr[4:2]);
    if (addr >= 32'd32) return 1'b1;
    if (addr % 4 != 0) return 1'b1;
    return wr && (idx >= 6);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int r = 0; r < 8; r++) m_reg[i][r] = 32'h0;
      m_reg[i][7] = 32'hA9B0_0001;
      m_prdata[i] = 32'h0;
    end
    exp_ready = '0;
    exp_err   = '0;
  endtask

  task automatic check(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check(pready_v[i] == exp_ready[i], $sformatf("pready[%0d]", i),
              32'(pready_v[i]), 32'(exp_ready[i]));
        check(prdata_v[i] == m_prdata[i], $sformatf("prdata[%0d]", i),
              prdata_v[i], m_prdata[i]);
        if (exp_ready[i])
          check(pslverr_v[i] == exp_err[i], $sformatf("pslverr[%0d]", i),
                32'(pslverr_v[i]), 32'(exp_err[i]));
      end
    end
  end

  // One transfer on instance i, starting at posedge+1 and returning at posedge+1
  // right after the final cycle so another transfer can follow back-to-back.
  // abort_at: access cycle in which psel is dropped (0 = never).
  task automatic xfer(input int i, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input int abort_at,
                      output logic [31:0] got_rdata, output bit got_err,
                      output int ready_k);
    int w;
    bit e;
    int idx;
    w = wait_of(i);
    e = model_err(addr, wr);
    idx = int'(addr[4:2]);
    got_rdata = 32'h0;
    got_err = 1'b0;
    ready_k = 0;
    psel_v[i] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    // Address and data must already be captured; scramble them.
    penable = 1'b1; paddr = $urandom(); pwdata = $urandom();
    for (int k = 1; k <= w + 1; k++) begin
      if (pready_v[i] && ready_k == 0) begin
        ready_k = k; got_rdata = prdata_v[i]; got_err = pslverr_v[i];
      end
      if (abort_at != 0 && k == abort_at) begin
        psel_v[i] = 1'b0;
        @(posedge clk); #1;
        break;
      end
      if (k == w + 1) begin
        exp_ready[i] = 1'b1;
        exp_err[i] = e;
        if (!wr) m_prdata[i] = e ? 32'h0 : m_reg[i][idx];
      end
      @(posedge clk); #1;
      if (k == w + 1) begin
        if (wr && !e) begin
          if (idx < 6) m_reg[i][idx] = data;
          m_reg[i][6] = m_reg[i][6] + 32'd1;
        end
        exp_ready[i] = 1'b0;
        exp_err[i] = 1'b0;
      end
    end
    psel_v[i] = 1'b0; penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [31:0] rd;
  bit          er;
  int          rk;

  initial begin
    n_pass = 0; n_total = 0; chk_en = 1'b0;
    rst_n = 1'b0; psel_v = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    model_reset();
    idle(3);
    for (int i = 0; i < 3; i++) begin
      check(pready_v[i] == 1'b0, "reset pready", 32'(pready_v[i]), 32'h0);
      check(prdata_v[i] == 32'h0, "reset prdata", prdata_v[i], 32'h0);
    end
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);

    // Write then read back with one wait state; counter reads 1.
    xfer(1, 1'b1, 32'h0, 32'h1234_5678, 0, rd, er, rk);
    xfer(1, 1'b0, 32'h0, 32'h0, 0, rd, er, rk);
    check(rk == 2, "w1 ready cycle", 32'(rk), 32'd2);
    check(rd == 32'h1234_5678, "w1 readback", rd, 32'h1234_5678);
    check(er == 1'b0, "w1 read err", 32'(er), 32'h0);
    xfer(1, 1'b0, 32'h18, 32'h0, 0, rd, er, rk);
    check(rd == 32'h1, "w1 counter", rd, 32'h1);

    // Zero wait states: ID read completes on the first access cycle.
    idle(1);
    xfer(0, 1'b0, 32'h1C, 32'h0, 0, rd, er, rk);
    check(rk == 1, "w0 ready cycle", 32'(rk), 32'd1);
    check(rd == 32'hA9B0_0001, "w0 id", rd, 32'hA9B0_0001);

    // Errored writes: read-only word, out of range, unaligned.
    xfer(1, 1'b1, 32'h18, 32'hDEAD_BEEF, 0, rd, er, rk);
    check(er == 1'b1, "err ro write", 32'(er), 32'h1);
    xfer(1, 1'b1, 32'h20, 32'hDEAD_BEEF, 0, rd, er, rk);
    check(er == 1'b1, "err range write", 32'(er), 32'h1);
    xfer(1, 1'b1, 32'h02, 32'hDEAD_BEEF, 0, rd, er, rk);
    check(er == 1'b1, "err unaligned write", 32'(er), 32'h1);
    xfer(1, 1'b0, 32'h18, 32'h0, 0, rd, er, rk);
    check(rd == 32'h1, "err counter kept", rd, 32'h1);
    xfer(1, 1'b0, 32'h0, 32'h0, 0, rd, er, rk);
    check(rd == 32'h1234_5678, "err reg0 kept", rd, 32'h1234_5678);
    xfer(1, 1'b0, 32'h20, 32'h0, 0, rd, er, rk);
    check(rd == 32'h0 && er == 1'b1, "err read zero", rd, 32'h0);

    // Abort during wait states: nothing commits.
    xfer(2, 1'b1, 32'h4, 32'hCAFE_F00D, 1, rd, er, rk);
    idle(1);
    xfer(2, 1'b0, 32'h4, 32'h0, 0, rd, er, rk);
    check(rk == 4, "w3 ready cycle", 32'(rk), 32'd4);
    check(rd == 32'h0, "abort no commit", rd, 32'h0);
    xfer(2, 1'b0, 32'h18, 32'h0, 0, rd, er, rk);
    check(rd == 32'h0, "abort counter", rd, 32'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 300; n++) begin
      int i, sel, ab;
      bit wr;
      logic [31:0] a;
      i = int'($urandom_range(0, 2));
      wr = 1'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel < 8) a = 32'($urandom_range(0, 7)) * 32'd4;
      else if (sel == 8) a = 32'($urandom_range(0, 7)) * 32'd4 + 32'($urandom_range(1, 3));
      else a = $urandom() | 32'h20;
      ab = 0;
      if (wait_of(i) > 0 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(1, wait_of(i)));
      xfer(i, wr, a, $urandom(), ab, rd, er, rk);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end

    // Counter wrap.
    force u_w1.u_regfile.wr_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release u_w1.u_regfile.wr_cnt_q;
    m_reg[1][6] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    xfer(1, 1'b1, 32'h8, 32'h5555_AAAA, 0, rd, er, rk);
    xfer(1, 1'b0, 32'h18, 32'h0, 0, rd, er, rk);
    check(rd == 32'h0, "counter wrap", rd, 32'h0);

    // Reset while an instance sits in its wait states.
    xfer(1, 1'b1, 32'h14, 32'h0BAD_CAFE, 0, rd, er, rk);
    chk_en = 1'b0;
    psel_v[2] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check(pready_v[2] == 1'b0, "reset mid pready", 32'(pready_v[2]), 32'h0);
    check(pslverr_v[2] == 1'b0, "reset mid pslverr", 32'(pslverr_v[2]), 32'h0);
    check(prdata_v[1] == 32'h0, "reset mid prdata", prdata_v[1], 32'h0);
    psel_v = '0; penable = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_en = 1'b1;
    idle(1);
    for (int r = 0; r < 8; r++) begin
      xfer(1, 1'b0, 32'(r * 4), 32'h0, 0, rd, er, rk);
      check(rd == ((r == 7) ? 32'hA9B0_0001 : 32'h0), $sformatf("post reset w%0d", r), rd,
            (r == 7) ? 32'hA9B0_0001 : 32'h0);
    end
    idle(2);
    chk_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
